mix_columns_seq: RTL

Sequencer that applies AES MixColumns to a full 128-bit state using a single shared 32-bit `mix_columns` instance, one column per clock. It sits in the round datapath between ShiftRows and AddRoundKey. It accepts a state over a valid/ready handshake, iterates columns 0..3 through the shared column mixer, and presents the assembled result over a second valid/ready handshake.

---
 rtl/mix_columns_seq.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mix_columns_seq.sv
// AES MixColumns sequencer: one shared 32-bit column mixer, one column per clock.
// Optional final-round pass-through of unmixed columns when MIX_COL_BYPASS_EN is defined.

module mix_columns (
    input  logic [31:0] col,
    output logic [31:0] mixed
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] a0, a1, a2, a3;

    assign {a0, a1, a2, a3} = col;

    assign mixed = {
        xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
        xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)
    };
endmodule

module mix_columns_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] state_in,
`ifdef MIX_COL_BYPASS_EN
    input  logic         bypass_i,
`endif
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] state_o,
    output logic         busy_o,
    output logic [1:0]   col_idx_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       st, st_nx;
    logic [127:0] work, result;
    logic [1:0]   col_idx;
    logic [31:0]  work_col, mix_out, wr_col;
    logic         accept;

    assign accept = in_valid_i && (st == IDLE);

    always_comb begin
        work_col = work[127:96];
        unique case (col_idx)
            2'd0: work_col = work[127:96];
            2'd1: work_col = work[95:64];
            2'd2: work_col = work[63:32];
            2'd3: work_col = work[31:0];
            default: work_col = work[127:96];
        endcase
    end

    mix_columns u_mix (
        .col   (work_col),
        .mixed (mix_out)
    );

`ifdef MIX_COL_BYPASS_EN
    logic bypass_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bypass_q <= 1'b0;
        else if (accept)
            bypass_q <= bypass_i;
    end

    // Final AES round skips MixColumns: pass the column through untouched
    assign wr_col = bypass_q ? work_col : mix_out;
`else
    assign wr_col = mix_out;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            st <= IDLE;
        else
            st <= st_nx;
    end

    always_comb begin
        st_nx       = st;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        unique case (st)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i)
                    st_nx = RUN;
            end
            RUN: begin
                busy_o = 1'b1;
                if (col_idx == 2'd3)
                    st_nx = DONE;
            end
            DONE: begin
                busy_o      = 1'b1;
                out_valid_o = 1'b1;
                if (out_ready_i)
                    st_nx = IDLE;
            end
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work    <= '0;
            result  <= '0;
            col_idx <= 2'd0;
        end else begin
            if (accept) begin
                work    <= state_in;
                col_idx <= 2'd0;
            end
            if (st == RUN) begin
                unique case (col_idx)
                    2'd0: result[127:96] <= wr_col;
                    2'd1: result[95:64]  <= wr_col;
                    2'd2: result[63:32]  <= wr_col;
                    2'd3: result[31:0]   <= wr_col;
                    default: ;
                endcase
                col_idx <= col_idx + 2'd1;
            end
        end
    end

    assign state_o   = result;
    assign col_idx_o = col_idx;
endmodule
